fifo_wr_arb: RTL and testbench

Two-requester round-robin write arbiter for the 8-bit dual-clock `fifo` IP, running in the FIFO write-clock domain. Each requester asks for a burst of 1..MAX_BURST words. The arbiter grants one requester at a time and drives the FIFO `wrreq`/`data` pins for that burst, stalling on `wrfull`. It sits between the data producers and `u_fifo`, replacing a single `fifo_wr` as the sole driver of the write port.

---
 rtl/fifo_wr_arb.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin write arbiter for the dual-clock fifo write port.
// Grants one requester at a time for a burst of 1..MAX_BURST words and drives
// wrreq/data for that burst, stalling while the FIFO reports full.
module fifo_wr_arb #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LEN_W     = 5
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  input  logic              wrfull,
  output logic              wrreq,
  output logic [DATA_W-1:0] data
);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] OneLen = LEN_W'(1);

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               sel_q, sel_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               pick;

  // Zero-length bursts still move one word; oversize requests saturate.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) begin
      return OneLen;
    end else if (l > MaxLen) begin
      return MaxLen;
    end else begin
      return l;
    end
  endfunction

  // State and arbitration registers; reset drops any partial burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
    end
  end

  // Next-state logic plus the combinational write-port outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    pick    = 1'b0;
    wrreq   = 1'b0;
    ack0    = 1'b0;
    ack1    = 1'b0;
    data    = '0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On contention, serve whoever was not served last.
          pick    = (req0 && req1) ? ~last_q : req1;
          sel_d   = pick;
          cnt_d   = clamp_len(pick ? len1 : len0);
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = StBurst;
        end
      end
      StBurst: begin
        wrreq = ~wrfull;
        data  = sel_q ? data1 : data0;
        ack0  = wrreq & ~sel_q;
        ack1  = wrreq & sel_q;
        if (wrreq) begin
          cnt_d = cnt_q - OneLen;
          if (cnt_q == OneLen) begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        last_d  = sel_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = (state_q == StDone) && !sel_q;
  assign done1 = (state_q == StDone) && sel_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: requester drivers feed bursts, a
// transaction-level model predicts the write stream, a monitor compares.
module tb_fifo_wr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, wrfull;
  logic [4:0] len0, len1;
  logic [7:0] data0, data1, data;
  logic       gnt0, gnt1, ack0, ack1, done0, done1, wrreq;

  always #5 clk = ~clk;

  fifo_wr_arb #(
    .DATA_W   (8),
    .MAX_BURST(16),
    .LEN_W    (5)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .req0     (req0),
    .req1     (req1),
    .len0     (len0),
    .len1     (len1),
    .data0    (data0),
    .data1    (data1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .ack0     (ack0),
    .ack1     (ack1),
    .done0    (done0),
    .done1    (done1),
    .wrfull   (wrfull),
    .wrreq    (wrreq),
    .data     (data)
  );

  typedef struct packed {
    logic       who;
    logic [7:0] d;
    logic       last;
  } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wr = 0;
  int last_m = 1;
  int taken0 = 0;
  int taken1 = 0;
  bit rand_full = 0;
  bit force_full = 0;
  bit drop_mode = 0;
  bit prev_end = 0;

  exp_t       exp_q[$];
  logic       exp_done[$];
  logic [4:0] dlen0[$], dlen1[$];
  logic [7:0] dw0[$], dw1[$];
  int         mlen0[$], mlen1[$];
  logic [7:0] mw0[$], mw1[$];
  int         wr_cycles[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue one burst for requester r; base<0 gives random data words.
  task automatic add_burst(input int r, input logic [4:0] len, input int base);
    int n;
    logic [7:0] w;
    n = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
    if (r == 0) begin dlen0.push_back(len); mlen0.push_back(n); end
    else begin dlen1.push_back(len); mlen1.push_back(n); end
    for (int i = 0; i < n; i++) begin
      w = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
      if (r == 0) begin dw0.push_back(w); mw0.push_back(w); end
      else begin dw1.push_back(w); mw1.push_back(w); end
    end
  endtask

  // Round-robin order of queued bursts, expanded to the expected word stream.
  task automatic predict();
    int pick;
    int n;
    exp_t e;
    while (mlen0.size() != 0 || mlen1.size() != 0) begin
      if (mlen0.size() != 0 && mlen1.size() != 0) pick = (last_m == 0) ? 1 : 0;
      else pick = (mlen1.size() != 0) ? 1 : 0;
      if (pick == 0) n = mlen0.pop_front();
      else n = mlen1.pop_front();
      for (int i = 0; i < n; i++) begin
        e.who  = pick[0];
        e.d    = (pick == 0) ? mw0.pop_front() : mw1.pop_front();
        e.last = (i == n - 1);
        exp_q.push_back(e);
      end
      exp_done.push_back(pick[0]);
      last_m = pick;
    end
  endtask

  task automatic flush();
    dlen0.delete(); dlen1.delete(); dw0.delete(); dw1.delete();
    mlen0.delete(); mlen1.delete(); mw0.delete(); mw1.delete();
    exp_q.delete(); exp_done.delete();
    taken0 = 0; taken1 = 0; prev_end = 0; last_m = 1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((dlen0.size() != 0 || dlen1.size() != 0 || exp_q.size() != 0 ||
            exp_done.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d words and %0d dones outstanding after %0d cycles",
               exp_q.size(), exp_done.size(), budget);
      flush();
      last_m = 32'(dut.last_q === 1'b1);
    end
    repeat (3) @(negedge clk);
  endtask

  // Requester drivers: advance data on ack, next burst on done.
  always begin : drv
    logic a0, a1, dn0, dn1;
    logic [7:0] junk;
    logic [4:0] ljunk;
    @(negedge clk);
    a0 = ack0; a1 = ack1; dn0 = done0; dn1 = done1;
    @(posedge clk);
    #1;
    if (a0 && dw0.size() != 0) begin junk = dw0.pop_front(); taken0++; end
    if (a1 && dw1.size() != 0) begin junk = dw1.pop_front(); taken1++; end
    if (dn0 && dlen0.size() != 0) begin ljunk = dlen0.pop_front(); taken0 = 0; end
    if (dn1 && dlen1.size() != 0) begin ljunk = dlen1.pop_front(); taken1 = 0; end
    req0   = (dlen0.size() != 0) && !(drop_mode && taken0 > 0);
    req1   = (dlen1.size() != 0) && !(drop_mode && taken1 > 0);
    len0   = (dlen0.size() != 0) ? dlen0[0] : 5'd0;
    len1   = (dlen1.size() != 0) ? dlen1[0] : 5'd0;
    data0  = (dw0.size() != 0) ? dw0[0] : 8'd0;
    data1  = (dw1.size() != 0) ? dw1[0] : 8'd0;
    wrfull = rand_full ? ($urandom_range(0, 3) == 0) : force_full;
  end

  // Monitor: pops the scoreboard on every write and every done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    logic w;
    bit now_end;
    now_end = 0;
    if (!rst_n) begin
      prev_end = 0;
    end else begin
      check("excl", {27'd0, ack0 & ~gnt0, ack1 & ~gnt1, gnt0 & gnt1, wrreq & wrfull,
                     ack0 & ack1}, 32'd0);
      if (wrreq) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got data %0h ack %0b%0b expected no write", data,
                   ack1, ack0);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(data), 32'(e.d));
          check("wr_who", {30'd0, ack1, ack0}, e.who ? 32'd2 : 32'd1);
          now_end = e.last;
        end
        n_wr++;
        wr_cycles.push_back(cyc);
      end
      if (done0 | done1) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done %0b%0b expected none", done1, done0);
        end else begin
          w = exp_done.pop_front();
          check("done_who", {30'd0, done1, done0}, w ? 32'd2 : 32'd1);
          check("done_after_last", 32'(prev_end), 32'd1);
        end
      end
      prev_end = now_end;
    end
  end

  initial begin
    int n0;
    int k;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; len0 = '0; len1 = '0; data0 = '0; data1 = '0; wrfull = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {17'd0, gnt0, gnt1, ack0, ack1, done0, done1, wrreq, data}, 32'd0);
    #2 rst_n = 1'b1;

    // Contention: alternating 0,1,0,1 with two idle cycles between bursts.
    @(negedge clk);
    wr_cycles.delete();
    add_burst(0, 5'd2, -1); add_burst(1, 5'd2, -1);
    add_burst(0, 5'd2, -1); add_burst(1, 5'd2, -1);
    predict();
    wait_drain(200);
    check("contention_words", 32'(wr_cycles.size()), 32'd8);
    if (wr_cycles.size() == 8)
      for (int i = 1; i < 8; i++)
        check("contention_gap", 32'(wr_cycles[i] - wr_cycles[i-1]), (i % 2) ? 32'd1 : 32'd3);

    // Single request, incrementing data 0..3.
    @(negedge clk);
    add_burst(0, 5'd4, 0);
    predict();
    @(negedge clk);
    check("gnt_not_yet", 32'(gnt0), 32'd0);
    @(negedge clk);
    check("gnt_latency", {29'd0, gnt0, wrreq, ack0}, 32'd7);
    wait_drain(100);
    check("idle_after", {30'd0, wrreq, gnt0}, 32'd0);

    // Full stall in the second burst cycle for five cycles.
    @(negedge clk);
    add_burst(1, 5'd3, -1);
    predict();
    k = 0;
    while (!gnt1 && k < 20) begin @(negedge clk); k++; end
    check("stall_gnt_seen", 32'(gnt1), 32'd1);
    force_full = 1;
    repeat (5) begin
      @(negedge clk);
      check("stall", {29'd0, wrreq, ack1, gnt1}, 32'd1);
    end
    force_full = 0;
    wait_drain(100);

    // Length clamping.
    n0 = n_wr;
    add_burst(0, 5'd0, -1); predict(); wait_drain(100);
    check("clamp_len0", 32'(n_wr - n0), 32'd1);
    n0 = n_wr;
    add_burst(0, 5'd31, -1); predict(); wait_drain(200);
    check("clamp_len31", 32'(n_wr - n0), 32'd16);

    // Request dropped after the first word still completes.
    drop_mode = 1;
    n0 = n_wr;
    add_burst(0, 5'd5, -1); predict(); wait_drain(100);
    check("drop_words", 32'(n_wr - n0), 32'd5);
    drop_mode = 0;

    // Random traffic with random back-pressure.
    rand_full = 1;
    repeat (6) begin
      @(negedge clk);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) add_burst(0, 5'($urandom_range(0, 20)), -1);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) add_burst(1, 5'($urandom_range(0, 20)), -1);
      predict();
      wait_drain(3000);
    end
    rand_full = 0;
    repeat (2) @(negedge clk);

    // Reset during word 3 of an 8-word burst.
    add_burst(0, 5'd8, -1);
    predict();
    n0 = n_wr;
    k = 0;
    while (n_wr < n0 + 2 && k < 50) begin @(negedge clk); k++; end
    check("pre_reset_words", 32'(n_wr - n0), 32'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async", {25'd0, gnt0, gnt1, wrreq, ack0, ack1, done0, done1}, 32'd0);
    flush();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    add_burst(1, 5'd2, -1);
    add_burst(0, 5'd2, -1);
    predict();
    @(negedge clk);
    @(negedge clk);
    check("post_reset_first", {30'd0, gnt1, gnt0}, 32'd1);
    wait_drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
